mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory-side stage directly upstream of the MDR: owns the word-addressed data RAM and produces Mdatain, the value the MDR loads when Read is asserted.
- Accepts Read/Write requests with address from the MAR and write data from MDR_q.
- Inserts a programmable number of wait states and signals completion with a one-cycle done pulse.
- The control unit holds MDRin/Read until done is seen.

Parameters:
- ADDR_W, 9, address width in bits.
- DEPTH, 512, number of 32-bit words implemented (must be ≤ 2^ADDR_W).
- WAIT_CYCLES, 2, wait states inserted before the access cycle; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  synchronous active-high reset.
- Read  input  1  read request; sampled only in IDLE.
- Write  input  1  write request; sampled only in IDLE.
- addr  input  ADDR_W  word address (MAR output).
- wdata  input  32  write data (MDR_q).
- Mdatain  output  32  registered read data to the MDR; holds until the next completed read.
- mem_busy  output  1  high whenever the FSM is not in IDLE.
- mem_done  output  1  one-cycle pulse: access complete; Mdatain valid for reads.
- mem_err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset: clr is synchronous and active-high; clock is clk. On a clr edge: state=IDLE, wait counter=0, Mdatain=0, mem_busy=0, mem_done=0, mem_err=0.
- RAM contents are not cleared by clr.
- clr has priority over every other event.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE, exactly one of Read/Write high at an edge:
  - Latch addr, wdata and op into internal registers.
  - Load counter with WAIT_CYCLES.
  - Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
- IDLE, Read and Write both high:
  - No access; mem_err=1 for the next cycle; stay in IDLE.
- IDLE, neither high: stay in IDLE.
- WAIT:
  - If counter==1, go to ACCESS; otherwise decrement.
  - WAIT therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS, on its closing edge:
  - Write: RAM[latched addr] <= latched wdata.
  - Read: Mdatain <= RAM[latched addr].
  - Go to DONE.
- DONE: mem_done=1 (combinational from state); next edge returns to IDLE unconditionally.
- Latency: request sampled at edge E0 → mem_done high in the cycle after edge E0+WAIT_CYCLES+1. Back-to-back requests are separated by at least one IDLE cycle.
- Requests are ignored outside IDLE. Changes to addr/wdata after E0 have no effect (latched).
- Write completion leaves Mdatain unchanged.
- Out-of-range address (latched addr ≥ DEPTH):
  - Read returns 32'h0.
  - Write is dropped.
  - mem_done still pulses; mem_err stays 0.
- Reset mid-operation:
  - clr during WAIT, or at the ACCESS closing edge, aborts; no RAM write is committed.
  - A write committed at an earlier edge persists.
- Read-after-write to the same address returns the new data. There is no bypass requirement because operations never overlap.
- mem_busy = (state != IDLE), including DONE.

Test Plan:
- clr for 1 cycle, then idle → Mdatain=0, mem_busy=0, mem_done=0, mem_err=0; repeat clr mid-WAIT → same values next cycle.
- WAIT_CYCLES=2: Write addr=9'h05, wdata=32'hDEADBEEF sampled at E0 → mem_busy high after E0, mem_done high only in the cycle after E3; Mdatain unchanged.
- Then Read addr=9'h05 → Mdatain=32'hDEADBEEF in the same cycle mem_done pulses; the value holds through later writes until the next read completes.
- Read and Write both high in IDLE → mem_err pulses 1 cycle, mem_busy stays 0; read of addr 9'h05 still returns 32'hDEADBEEF.
- Write addr=9'h10, wdata=32'h12345678, with clr asserted at the edge that would close ACCESS → read of 9'h10 returns its prior value; mem_done never pulses for the aborted op.
- WAIT_CYCLES=0 build: Read sampled at E0 → mem_done in the cycle after E1. A new Read asserted while busy is ignored. DEPTH=300 with addr=9'h1FF → Read returns 32'h0 with mem_done; Write is dropped.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory-side stage feeding the MDR. It owns the word-addressed data RAM,
// inserts WAIT_CYCLES wait states per access and pulses mem_done on completion.
module mem_ctrl #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       Mdatain,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_op_wr;
  logic              r_err;
  logic [31:0]       r_mdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_req_one;
  logic              w_req_both;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_req_one  = Read ^ Write;
  assign w_req_both = Read & Write;
  // Addresses at or beyond DEPTH read as zero and swallow writes.
  assign w_in_range = (32'(r_addr) < DEPTH);
  assign w_idx      = r_addr[IDX_W-1:0];

  assign Mdatain = r_mdata;
  assign mem_err = r_err;

  // State register; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_req_one) begin
          w_state_next = (WAIT_CYCLES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (r_cnt == 4'd1) begin
          w_state_next = StAccess;
        end
      end
      StAccess: w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    mem_busy = (r_state != StIdle);
    mem_done = (r_state == StDone);
  end

  // Request latch, wait counter, error pulse and read-data register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
      r_err   <= 1'b0;
      r_mdata <= '0;
    end else begin
      r_err <= (r_state == StIdle) && w_req_both;
      if (r_state == StIdle && w_req_one) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_op_wr <= Write;
        r_cnt   <= WAIT_INIT;
      end else if (r_state == StWait && r_cnt != 4'd1) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == StAccess && !r_op_wr) begin
        r_mdata <= w_in_range ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  // RAM write port; contents survive clr, but a clr at the access edge blocks the commit.
  always_ff @(posedge clk) begin
    if (!clr && r_state == StAccess && r_op_wr && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule
